// File: rtl/mult_ctrl_pkg.sv
// Shared types and key decoding for the keypad-to-multiplier sequencer.
package mult_ctrl_pkg;

  typedef enum logic [2:0] {
    StEnterA = 3'd0,
    StEnterB = 3'd1,
    StStart  = 3'd2,
    StWait   = 3'd3,
    StShow   = 3'd4
  } state_t;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  function automatic logic is_digit(logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/key_event_detect.sv
// Turns the level-style debounced key stream into a single-cycle key event.
module key_event_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_available,
  input  logic [3:0] key_code,
  output logic       key_evt,
  output logic [3:0] key_val
);

  logic avail_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      avail_q <= 1'b0;
    end else begin
      avail_q <= data_available;
    end
  end

  // Event fires on the first cycle of a press so the FSM acts in the same cycle.
  always_comb begin
    key_evt = data_available & ~avail_q;
    key_val = key_code;
  end

endmodule

// File: rtl/keypad_mult_ctrl.sv
// Collects two decimal operands from the keypad, runs the multiplier and holds the product.
module keypad_mult_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned OP_W    = 7,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_available,
  input  logic [3:0]        key_code,
  input  logic              mult_done,
  input  logic [2*OP_W-1:0] mult_result,
  output logic [OP_W-1:0]   op_a,
  output logic [OP_W-1:0]   op_b,
  output logic              mult_start,
  output logic [OP_W-1:0]   entry_val,
  output logic [2*OP_W-1:0] product_o,
  output logic              product_valid,
  output logic              error,
  output logic [2:0]        phase
);

  localparam int unsigned CntW = $clog2(DIGITS + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] DigitsMax = CntW'(DIGITS);
  localparam logic [TmoW-1:0] TmoLast   = TmoW'(TIMEOUT - 1);
  localparam logic [OP_W-1:0] Ten       = OP_W'(10);

  logic       key_evt;
  logic [3:0] key_val;

  key_event_detect u_key_event_detect (
    .clk            (clk),
    .rst            (rst),
    .data_available (data_available),
    .key_code       (key_code),
    .key_evt        (key_evt),
    .key_val        (key_val)
  );

  state_t            state_q, state_d;
  logic [OP_W-1:0]   acc_q, acc_d, op_a_q, op_a_d, op_b_q, op_b_d, acc_next;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [2*OP_W-1:0] prod_q, prod_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEnterA;
      acc_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  assign acc_next = acc_q * Ten + OP_W'(key_val);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    prod_d  = prod_q;
    err_d   = err_q;

    if (key_evt) err_d = 1'b0;

    unique case (state_q)
      StEnterA, StEnterB: begin
        if (key_evt) begin
          if (is_digit(key_val)) begin
            // Digits past the operand width are silently dropped.
            if (cnt_q < DigitsMax) begin
              acc_d = acc_next;
              cnt_d = cnt_q + CntW'(1);
              if (state_q == StEnterA) op_a_d = acc_next;
              else                     op_b_d = acc_next;
            end
          end else if (key_val == KEY_ENTER) begin
            if (cnt_q != '0) begin
              acc_d   = '0;
              cnt_d   = '0;
              state_d = (state_q == StEnterA) ? StEnterB : StStart;
            end
          end else if (key_val == KEY_CLEAR) begin
            acc_d   = '0;
            cnt_d   = '0;
            op_a_d  = '0;
            op_b_d  = '0;
            state_d = StEnterA;
          end
        end
      end
      StStart: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A done arriving on the timeout cycle still counts as success.
        if (mult_done) begin
          prod_d  = mult_result;
          state_d = StShow;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          op_a_d  = '0;
          op_b_d  = '0;
          prod_d  = '0;
          state_d = StEnterA;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StShow: begin
        if (key_evt) begin
          if (is_digit(key_val)) begin
            acc_d   = OP_W'(key_val);
            cnt_d   = CntW'(1);
            op_a_d  = OP_W'(key_val);
            op_b_d  = '0;
            prod_d  = '0;
            state_d = StEnterA;
          end else if (key_val == KEY_CLEAR) begin
            acc_d   = '0;
            cnt_d   = '0;
            op_a_d  = '0;
            op_b_d  = '0;
            prod_d  = '0;
            state_d = StEnterA;
          end
        end
      end
      default: state_d = StEnterA;
    endcase
  end

  always_comb begin
    op_a          = op_a_q;
    op_b          = op_b_q;
    entry_val     = acc_q;
    product_o     = prod_q;
    mult_start    = (state_q == StStart);
    product_valid = (state_q == StShow);
    error         = err_q;
    phase         = state_q;
  end

endmodule

// File: tb/tb_keypad_mult_ctrl.sv
// Directed bench for keypad_mult_ctrl with hand-computed expectations.
module tb_keypad_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_available = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        mult_done = 1'b0;
  logic [13:0] mult_result = '0;
  logic [6:0]  op_a, op_b, entry_val;
  logic        mult_start, product_valid, error;
  logic [13:0] product_o;
  logic [2:0]  phase;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  keypad_mult_ctrl #(
    .DIGITS  (2),
    .OP_W    (7),
    .TIMEOUT (1024)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_available (data_available),
    .key_code       (key_code),
    .mult_done      (mult_done),
    .mult_result    (mult_result),
    .op_a           (op_a),
    .op_b           (op_b),
    .mult_start     (mult_start),
    .entry_val      (entry_val),
    .product_o      (product_o),
    .product_valid  (product_valid),
    .error          (error),
    .phase          (phase)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    data_available = 1'b1;
    key_code       = k;
    tick();
    data_available = 1'b0;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_phase"}, 32'(phase), 0);
    chk({tag, "_op_a"}, 32'(op_a), 0);
    chk({tag, "_op_b"}, 32'(op_b), 0);
    chk({tag, "_entry"}, 32'(entry_val), 0);
    chk({tag, "_prod"}, 32'(product_o), 0);
    chk({tag, "_start"}, 32'(mult_start), 0);
    chk({tag, "_valid"}, 32'(product_valid), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    chk_reset_state("rst");
    rst = 1'b1;
    tick();

    // 12 x 34
    press(4'd1);
    press(4'd2);
    chk("a_entry12", 32'(entry_val), 12);
    chk("a_op12", 32'(op_a), 12);
    press(4'hA);
    chk("a_enter_phase", 32'(phase), 1);
    chk("a_enter_clr", 32'(entry_val), 0);
    press(4'd3);
    press(4'd4);
    chk("b_op34", 32'(op_b), 34);
    data_available = 1'b1;
    key_code       = 4'hA;
    tick();
    chk("start_phase", 32'(phase), 2);
    chk("start_pulse", 32'(mult_start), 1);
    data_available = 1'b0;
    tick();
    chk("wait_phase", 32'(phase), 3);
    chk("start_once", 32'(mult_start), 0);
    // Keys in WAIT are discarded
    press(4'd9);
    press(4'hC);
    chk("wait_key_phase", 32'(phase), 3);
    chk("wait_key_entry", 32'(entry_val), 0);
    chk("wait_key_opa", 32'(op_a), 12);
    mult_done   = 1'b1;
    mult_result = 14'd408;
    tick();
    mult_done = 1'b0;
    chk("show_prod", 32'(product_o), 408);
    chk("show_valid", 32'(product_valid), 1);
    chk("show_phase", 32'(phase), 4);
    chk("show_opa", 32'(op_a), 12);
    chk("show_opb", 32'(op_b), 34);

    // SHOW: ENTER ignored, digit restarts entry
    press(4'hA);
    chk("show_enter_ign", 32'(phase), 4);
    press(4'd7);
    chk("show7_phase", 32'(phase), 0);
    chk("show7_entry", 32'(entry_val), 7);
    chk("show7_valid", 32'(product_valid), 0);
    chk("show7_prod", 32'(product_o), 0);
    chk("show7_opb", 32'(op_b), 0);

    // Held key yields one digit; third digit dropped
    press(4'hC);
    data_available = 1'b1;
    key_code       = 4'd5;
    repeat (500) tick();
    data_available = 1'b0;
    tick();
    chk("hold_entry5", 32'(entry_val), 5);
    press(4'hC);
    press(4'd1);
    press(4'd2);
    press(4'd3);
    chk("drop_entry12", 32'(entry_val), 12);

    // ENTER with no digits, CLEAR in ENTER_B
    press(4'hC);
    press(4'hA);
    chk("empty_enter", 32'(phase), 0);
    press(4'd9);
    press(4'hA);
    chk("nine_enter", 32'(phase), 1);
    press(4'd4);
    press(4'hC);
    chk("clr_phase", 32'(phase), 0);
    chk("clr_opa", 32'(op_a), 0);
    chk("clr_opb", 32'(op_b), 0);
    chk("clr_entry", 32'(entry_val), 0);

    // Timeout boundary
    press(4'd1);
    press(4'hA);
    press(4'd2);
    press(4'hA);
    chk("tmo_wait", 32'(phase), 3);
    repeat (1023) tick();
    chk("tmo_edge_phase", 32'(phase), 3);
    chk("tmo_edge_err", 32'(error), 0);
    tick();
    chk("tmo_phase", 32'(phase), 0);
    chk("tmo_err", 32'(error), 1);
    chk("tmo_opa", 32'(op_a), 0);
    press(4'd6);
    chk("tmo_err_clr", 32'(error), 0);
    chk("tmo_entry6", 32'(entry_val), 6);

    // mult_done on the timeout cycle wins
    press(4'hA);
    press(4'd5);
    press(4'hA);
    repeat (1023) tick();
    mult_done   = 1'b1;
    mult_result = 14'd30;
    tick();
    mult_done = 1'b0;
    chk("race_phase", 32'(phase), 4);
    chk("race_prod", 32'(product_o), 30);
    chk("race_err", 32'(error), 0);

    // mult_done outside WAIT ignored
    mult_done   = 1'b1;
    mult_result = 14'd99;
    tick();
    mult_done = 1'b0;
    chk("late_done_prod", 32'(product_o), 30);
    press(4'hC);
    chk("show_clr_phase", 32'(phase), 0);
    chk("show_clr_prod", 32'(product_o), 0);

    // Reset mid-WAIT, then a stray done
    press(4'd3);
    press(4'hA);
    press(4'd3);
    press(4'hA);
    chk("rstw_wait", 32'(phase), 3);
    rst = 1'b0;
    #2;
    chk("rstw_async", 32'(phase), 0);
    tick();
    rst = 1'b1;
    tick();
    mult_done   = 1'b1;
    mult_result = 14'd9;
    tick();
    mult_done = 1'b0;
    tick();
    chk_reset_state("rstw");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
